conv_stream_engine: RTL
=======================

// Module: conv_stream_engine
// PURPOSE
//  Sequential, parametrised successor of the combinational 8x8x1 / 3x3x3 convolution block.
//  Snapshots one flattened image and kernel set on start.
//  Computes one valid-mode output element per cycle using K*K parallel MACs.
//  Streams results over a valid/ready port into downstream pooling/FC stages.
// PARAMETERS
//  IMG_H   8  input rows
//  IMG_W   8  input columns
//  K       3  kernel size (KxK); OUT_H=IMG_H-K+1, OUT_W=IMG_W-K+1 (derived localparams)
//  CH      3  output channels (single input channel)
//  DW      8  data/weight/result width, two's complement
//  SHIFT   0  arithmetic right shift applied to each sum before saturation
// PORTS
//  clk         in   1                  clock, rising edge
//  rst         in   1                  asynchronous, active-high reset
//  start       in   1                  start request; accepted only in IDLE
//  data_lin    in   IMG_H*IMG_W*DW     pixel (r,c) at bits [(r*IMG_W+c)*DW +: DW]
//  weight_lin  in   K*K*CH*DW          tap (ch,kr,kc) at [((ch*K+kr)*K+kc)*DW +: DW]
//  busy        out  1                  high from start acceptance until the done cycle ends
//  out_valid   out  1                  out_data/out_idx hold a valid result
//  out_ready   in   1                  downstream accepts; a handshake occurs on out_valid&&out_ready
//  out_data    out  DW                 result element
//  out_idx     out  clog2(CH*OUT_H*OUT_W)  idx = ch*OUT_H*OUT_W + r*OUT_W + c
//  done        out  1                  one-cycle pulse after the last handshake
// BEHAVIOUR
//  Reset: all outputs, counters and snapshot registers are 0; FSM enters IDLE.
//  FSM: IDLE --start--> RUN --last handshake--> DONE (1 cycle) --> IDLE.
//  - IDLE: start latches data_lin/weight_lin into internal regs and zeroes counters (ch,r,c).
//    busy rises on the next edge.
//  - Inputs are not sampled again until the next accepted start; start in RUN or DONE is ignored.
//  - RUN: output register loads when empty or on the same cycle it hands off (no bubble).
//    Sustained rate is 1 element/clk with out_ready held high.
//  - Latency: first out_valid is 2 clk after the start edge.
//  - Order: c fastest, then r, then ch; out_idx increments by 1 per handshake.
//  - Backpressure: while out_valid && !out_ready, out_data, out_idx and the counters are frozen.
//    No element is dropped or duplicated.
//  - Last element: on the handshake of idx CH*OUT_H*OUT_W-1, out_valid drops next edge.
//    DONE is entered then: done=1 and busy=1 for that cycle; both are 0 afterwards.
//  - start coinciding with the DONE cycle is ignored; it must be reissued in IDLE.
//  - rst mid-frame: immediate asynchronous abort; outputs are 0 and no done pulse is produced.
//  Arithmetic
//  - Products are signed DW x DW -> 2*DW.
//  - Sum width is 2*DW+clog2(K*K), with no intermediate overflow.
//  - sum >>> SHIFT (arithmetic).
//  - Saturate to [-2^(DW-1), 2^(DW-1)-1]: 127 / -128 for DW=8.
// CONFIGURATION
//  CONV_RELU_EN defined:   after saturation, negative results are forced to 0; range is [0, 127].
//  CONV_RELU_EN undefined: signed saturated result is passed through unchanged.
//  Timing, ordering and handshake are identical in both builds.
// TESTING (defaults unless stated; 108 outputs per frame)
//  1 data all 0, random weights, out_ready=1
//    -> 108 handshakes, all out_data=0, out_idx 0..107 in order.
//    -> done pulses once, 1 clk after idx 107; first valid 2 clk after start.
//  2 data all 1; weights ch0 all 1, ch1 all -1, ch2 centre 5 else 0
//    -> idx 0-35 = 9, idx 36-71 = -9 (0 with CONV_RELU_EN), idx 72-107 = 5.
//  3 saturation
//    -> data all 127, weights all 127: every output = 127.
//    -> data all -128, weights all 127: every output = -128 (0 with CONV_RELU_EN).
//  4 out_ready low for 5 clk while idx 10 is presented
//    -> out_data/out_idx stable at idx 10 throughout, no skipped index, 108 total handshakes.
//  5 start re-pulsed at idx 20; then rst pulsed at idx 50
//    -> re-pulse ignored, frame continues.
//    -> after rst: busy/out_valid/done = 0 immediately; next start restarts at idx 0 with fresh inputs.
//  6 SHIFT=2, data all 1, weights all 1 -> every output = 9>>>2 = 2.
//    Also: IMG_H=IMG_W=10, K=5, CH=2 -> 72 outputs, done after idx 71.

Source files
------------

// File: rtl/conv_stream_engine.sv
// conv_stream_engine: sequential valid-mode 2-D convolution.
// On an accepted start, one image and its kernel set are snapshotted. The engine
// then produces one output element per clock using K*K parallel multipliers, in a
// two-stage pipeline (products, then sum/shift/saturate), and streams the results
// over a valid/ready port.
// Optional build macro: CONV_RELU_EN clamps negative saturated results to zero.
//
// Handshake: a transfer happens on a rising edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_data and out_idx hold, and the
// whole pipeline stalls with them.
module conv_stream_engine #(
   parameter int IMG_H = 8,
   parameter int IMG_W = 8,
   parameter int K     = 3,
   parameter int CH    = 3,
   parameter int DW    = 8,
   parameter int SHIFT = 0,
   localparam int OUT_H = IMG_H - K + 1,
   localparam int OUT_W = IMG_W - K + 1,
   localparam int NOUT  = CH * OUT_H * OUT_W,
   localparam int IW    = (NOUT > 1) ? $clog2(NOUT) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [IMG_H*IMG_W*DW-1:0] data_lin,
   input  logic [K*K*CH*DW-1:0]    weight_lin,
   output logic                    busy,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DW-1:0]           out_data,
   output logic [IW-1:0]           out_idx,
   output logic                    done
);

   localparam int SW  = 2 * DW + $clog2(K * K);
   localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
   localparam int RW  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
   localparam int CW  = (OUT_W > 1) ? $clog2(OUT_W) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CHW-1:0] CH_LAST  = CHW'(CH - 1);
   localparam logic [RW-1:0]  R_LAST   = RW'(OUT_H - 1);
   localparam logic [CW-1:0]  C_LAST   = CW'(OUT_W - 1);
   localparam logic [IW-1:0]  IDX_LAST = IW'(NOUT - 1);

   localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DW - 1)) - 1);
   localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

   logic [1:0]                state_q;
   logic [IMG_H*IMG_W*DW-1:0] img_q;
   logic [K*K*CH*DW-1:0]      wgt_q;
   logic [CHW-1:0]            ch_q;
   logic [RW-1:0]             r_q;
   logic [CW-1:0]             c_q;
   logic [IW-1:0]             iss_idx_q;
   logic [IW-1:0]             p_idx_q;
   logic                      issuing_q;
   logic                      p_valid_q;
   logic signed [2*DW-1:0]    p_prod_q [K*K];
   logic signed [2*DW-1:0]    prod_d   [K*K];
   logic signed [SW-1:0]      sum;
   logic signed [SW-1:0]      shifted;
   logic [DW-1:0]             res;
   logic                      adv;
   logic                      last_hs;
   logic                      last_issue;
   int                        pix_base;
   int                        wgt_base;

   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign adv        = !out_valid || out_ready;
   assign last_hs    = out_valid && out_ready && (out_idx == IDX_LAST);
   assign last_issue = (ch_q == CH_LAST) && (r_q == R_LAST) && (c_q == C_LAST);

   // K*K parallel signed products for the window addressed by (ch_q, r_q, c_q)
   always_comb begin
      pix_base = 0;
      wgt_base = 0;
      for (int kr = 0; kr < K; kr++) begin
         for (int kc = 0; kc < K; kc++) begin
            pix_base = ((int'(r_q) + kr) * IMG_W + int'(c_q) + kc) * DW;
            wgt_base = ((int'(ch_q) * K + kr) * K + kc) * DW;
            prod_d[kr*K+kc] = $signed(img_q[pix_base +: DW]) * $signed(wgt_base >= 0 ? wgt_q[wgt_base +: DW] : wgt_q[DW-1:0]);
         end
      end
   end

   // Wide sum of registered products, arithmetic shift, then saturation (and optional ReLU)
   always_comb begin
      sum = '0;
      for (int i = 0; i < K * K; i++) begin
         sum = sum + SW'(p_prod_q[i]);
      end
      shifted = sum >>> SHIFT;
      if (shifted > SAT_MAX) begin
         res = SAT_MAX[DW-1:0];
      end else if (shifted < SAT_MIN) begin
         res = SAT_MIN[DW-1:0];
      end else begin
         res = shifted[DW-1:0];
      end
`ifdef CONV_RELU_EN
      if (res[DW-1]) begin
         res = '0;
      end
`else
`endif
   end

   // Control FSM, input snapshot, window counters and output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         img_q     <= '0;
         wgt_q     <= '0;
         ch_q      <= '0;
         r_q       <= '0;
         c_q       <= '0;
         iss_idx_q <= '0;
         p_idx_q   <= '0;
         issuing_q <= 1'b0;
         p_valid_q <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  img_q     <= data_lin;
                  wgt_q     <= weight_lin;
                  ch_q      <= '0;
                  r_q       <= '0;
                  c_q       <= '0;
                  iss_idx_q <= '0;
                  issuing_q <= 1'b1;
                  p_valid_q <= 1'b0;
                  out_valid <= 1'b0;
                  state_q   <= S_RUN;
               end
            end
            S_RUN: begin
               if (adv) begin
                  out_valid <= p_valid_q;
                  if (p_valid_q) begin
                     out_data <= res;
                     out_idx  <= p_idx_q;
                  end
                  p_valid_q <= issuing_q;
                  if (issuing_q) begin
                     p_idx_q   <= iss_idx_q;
                     iss_idx_q <= iss_idx_q + 1'b1;
                     if (last_issue) begin
                        issuing_q <= 1'b0;
                     end
                     // c fastest, then r, then ch
                     if (c_q == C_LAST) begin
                        c_q <= '0;
                        if (r_q == R_LAST) begin
                           r_q <= '0;
                           if (ch_q == CH_LAST) begin
                              ch_q <= '0;
                           end else begin
                              ch_q <= ch_q + 1'b1;
                           end
                        end else begin
                           r_q <= r_q + 1'b1;
                        end
                     end else begin
                        c_q <= c_q + 1'b1;
                     end
                  end
               end
               if (last_hs) begin
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Product stage advances together with the output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < K * K; i++) begin
            p_prod_q[i] <= '0;
         end
      end else if ((state_q == S_RUN) && adv && issuing_q) begin
         p_prod_q <= prod_d;
      end
   end

endmodule
